cavlc_level_sched: RTL and testbench

Sequencer for the CAVLC level coding stage. It accepts the non-trailing-one coefficient levels of one 4x4 block, one per beat, in reverse zigzag order. For each level it computes the prefix/suffix/suffixLength triple using the adaptive suffixLength rules. It issues the results as pairs to the two-level bit packer and holds each pair until the downstream bitstream writer accepts the packed word.

---
 rtl/cavlc_pkg.sv | 22 ++
 rtl/cavlc_level_code.sv | 97 +++++++++
 rtl/cavlc_level_sched.sv | 225 ++++++++++++++++++++++
 tb/tb_cavlc_level_sched.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cavlc_pkg.sv
// Shared constants and types for the CAVLC level coding stage.
// Holds the level and suffixLength widths, the escape constants used by the
// level-code mapper, and the scheduler FSM state encoding.
package cavlc_pkg;

    localparam int LEVEL_W     = 16;          // signed level width
    localparam int CODE_W      = LEVEL_W + 1; // levelCode width, holds 2*|lvl|-1
    localparam int SL_MAX      = 6;           // suffixLength ceiling
    localparam int SL_W        = 3;           // enough bits for 0..SL_MAX
    localparam int ESC_PREFIX  = 15;          // prefix used by every escape
    localparam int ESC_SUFLEN  = 12;          // suffix length used by every escape
    localparam int ESC_THRESH0 = 14;          // sl=0: first levelCode needing a suffix
    localparam int ESC_THRESH1 = 30;          // sl=0: first levelCode needing the escape
    localparam int SUFFIX_SAT  = 4095;        // largest escape suffix that fits 12 bits

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } state_t;

endpackage

// File: rtl/cavlc_level_code.sv
// Purely combinational level-code mapper.
// Turns one signed level plus the current suffixLength into the
// prefix / suffix / suffix-length triple and the suffixLength to use for
// the next level.
//   lvl       : signed level (nonzero)
//   sl        : current suffixLength, 0..SL_MAX
//   first_adj : subtract 2 from levelCode (first level, fewer than 3 trailing ones)
//   prefix    : leading-zero count
//   suffix    : right-aligned suffix value
//   suflen    : suffix length in bits, {0..6, 12}
//   sl_next   : suffixLength after this level
//   ovf       : escape suffix saturated at SUFFIX_SAT
module cavlc_level_code
    import cavlc_pkg::*;
(
    input  logic [LEVEL_W-1:0] lvl,
    input  logic [SL_W-1:0]    sl,
    input  logic               first_adj,
    output logic [4:0]         prefix,
    output logic [14:0]        suffix,
    output logic [3:0]         suflen,
    output logic [SL_W-1:0]    sl_next,
    output logic               ovf
);

    logic              neg;
    logic [CODE_W-1:0] mag;      // |lvl|, one bit wider so -32768 fits
    logic [CODE_W-1:0] code;
    logic [CODE_W-1:0] thresh;   // 15 << sl, first escape code for sl>0
    logic [CODE_W-1:0] esc;
    logic              is_esc;
    logic [SL_W-1:0]   sl1;      // sl after the 0 -> 1 step
    logic [CODE_W-1:0] grow_lim; // 3 << (sl1-1)

    always_comb begin
        // NOTE: every output and temporary gets a default before any branch
        // so no path leaves a value unassigned and no latch is inferred.
        prefix   = '0;
        suffix   = '0;
        suflen   = '0;
        ovf      = 1'b0;
        is_esc   = 1'b0;
        esc      = '0;

        // NOTE: blocking assignments here on purpose; later statements in
        // this block read the values just computed (code is refined twice).
        neg    = lvl[LEVEL_W-1];
        mag    = neg ? (CODE_W'(0) - {lvl[LEVEL_W-1], lvl}) : {1'b0, lvl};
        code   = (mag << 1) - (neg ? CODE_W'(1) : CODE_W'(2));
        if (first_adj) begin
            code = code - CODE_W'(2);
        end
        thresh = CODE_W'(15) << sl;

        if (sl == '0) begin
            if (code < CODE_W'(ESC_THRESH0)) begin
                prefix = 5'(code);
            end else if (code < CODE_W'(ESC_THRESH1)) begin
                prefix = 5'(ESC_THRESH0);
                suffix = 15'(code - CODE_W'(ESC_THRESH0));
                suflen = 4'd4;
            end else begin
                is_esc = 1'b1;
                esc    = code - CODE_W'(ESC_THRESH1);
            end
        end else begin
            if (code < thresh) begin
                prefix = 5'(code >> sl);
                suffix = 15'(code & ((CODE_W'(1) << sl) - CODE_W'(1)));
                suflen = 4'(sl);
            end else begin
                is_esc = 1'b1;
                esc    = code - thresh;
            end
        end

        if (is_esc) begin
            prefix = 5'(ESC_PREFIX);
            suflen = 4'(ESC_SUFLEN);
            if (esc > CODE_W'(SUFFIX_SAT)) begin
                suffix = 15'(SUFFIX_SAT);
                ovf    = 1'b1;
            end else begin
                suffix = 15'(esc);
            end
        end

        // Growth test uses the suffixLength after the 0 -> 1 promotion.
        sl1      = (sl == '0) ? SL_W'(1) : sl;
        grow_lim = CODE_W'(3) << (sl1 - SL_W'(1));
        sl_next  = sl1;
        if ((mag > grow_lim) && (sl1 < SL_W'(SL_MAX))) begin
            sl_next = sl1 + SL_W'(1);
        end
    end

endmodule

// File: rtl/cavlc_level_sched.sv
// CAVLC level scheduler.
// Accepts the non-trailing-one levels of one 4x4 block (reverse zigzag, one
// per beat), codes each with the adaptive suffixLength rules, and presents
// them in pairs to the two-level bit packer, holding each pair until the
// bitstream writer accepts it.
//   clk, rst_n          : clock, asynchronous active-low reset
//   clr                 : synchronous abort back to IDLE, highest priority
//   start               : block start pulse, honoured only in IDLE
//   total_coeff         : coefficients in the block, sampled on start
//   trailing_ones       : trailing ones, sampled on start
//   lvl_valid/lvl_ready : level beat handshake, lvl_data is the signed level
//   pk_enable           : packer slot enables (bit0 = slot0)
//   pk_prefix/suffix/suflen{0,1} : registered per-slot coding results
//   out_valid/out_ready : packed-word handshake with the writer
//   done                : one-cycle pulse when the block completes
//   err                 : one-cycle pulse after accepting a saturated escape
module cavlc_level_sched
    import cavlc_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               start,
    input  logic [4:0]         total_coeff,
    input  logic [1:0]         trailing_ones,
    input  logic               lvl_valid,
    input  logic [LEVEL_W-1:0] lvl_data,
    output logic               lvl_ready,
    output logic [1:0]         pk_enable,
    output logic [4:0]         pk_prefix0,
    output logic [4:0]         pk_prefix1,
    output logic [14:0]        pk_suffix0,
    output logic [14:0]        pk_suffix1,
    output logic [3:0]         pk_suflen0,
    output logic [3:0]         pk_suflen1,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               done,
    output logic               err
);

    state_t state_q, state_d;

    logic [4:0]      rem_q;       // levels still to accept
    logic [SL_W-1:0] sl_q;
    logic            first_q;     // next accepted level is the block's first
    logic            adj_q;       // block has fewer than 3 trailing ones
    logic            ptr_q;       // slot the next accepted level goes to
    logic [4:0]      slot0_prefix_q;
    logic [14:0]     slot0_suffix_q;
    logic [3:0]      slot0_suflen_q;
    logic [1:0]      pk_enable_q;
    logic [4:0]      pk_prefix0_q, pk_prefix1_q;
    logic [14:0]     pk_suffix0_q, pk_suffix1_q;
    logic [3:0]      pk_suflen0_q, pk_suflen1_q;
    logic            done_q;
    logic            err_q;

    logic [4:0]      cur_prefix;
    logic [14:0]     cur_suffix;
    logic [3:0]      cur_suflen;
    logic [SL_W-1:0] cur_sl_next;
    logic            cur_ovf;

    logic [4:0]      n_levels;
    logic            accept;
    logic            pair_done;
    logic            handshake;

    assign n_levels  = total_coeff - 5'(trailing_ones);
    assign accept    = (state_q == LOAD) && lvl_valid;
    // A pair closes on the slot1 write, or on a slot0 write of the last level.
    assign pair_done = accept && (ptr_q || (rem_q == 5'd1));
    assign handshake = (state_q == SEND) && out_ready;

    cavlc_level_code u_code (
        .lvl       (lvl_data),
        .sl        (sl_q),
        .first_adj (first_q & adj_q),
        .prefix    (cur_prefix),
        .suffix    (cur_suffix),
        .suflen    (cur_suflen),
        .sl_next   (cur_sl_next),
        .ovf       (cur_ovf)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: if (start && (n_levels != '0)) state_d = LOAD;
                LOAD: if (pair_done)                 state_d = SEND;
                SEND: if (out_ready)                 state_d = (rem_q != '0) ? LOAD : IDLE;
                default:                             state_d = IDLE;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        lvl_ready = (state_q == LOAD);
        out_valid = (state_q == SEND);
    end

    // Datapath: block context, slot0 holding register, packer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q          <= '0;
            sl_q           <= '0;
            first_q        <= 1'b0;
            adj_q          <= 1'b0;
            ptr_q          <= 1'b0;
            slot0_prefix_q <= '0;
            slot0_suffix_q <= '0;
            slot0_suflen_q <= '0;
            pk_enable_q    <= '0;
            pk_prefix0_q   <= '0;
            pk_prefix1_q   <= '0;
            pk_suffix0_q   <= '0;
            pk_suffix1_q   <= '0;
            pk_suflen0_q   <= '0;
            pk_suflen1_q   <= '0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
        end else if (clr) begin
            // Abort: everything back to idle values, pending done/err dropped.
            rem_q          <= '0;
            sl_q           <= '0;
            first_q        <= 1'b0;
            adj_q          <= 1'b0;
            ptr_q          <= 1'b0;
            slot0_prefix_q <= '0;
            slot0_suffix_q <= '0;
            slot0_suflen_q <= '0;
            pk_enable_q    <= '0;
            pk_prefix0_q   <= '0;
            pk_prefix1_q   <= '0;
            pk_suffix0_q   <= '0;
            pk_suffix1_q   <= '0;
            pk_suflen0_q   <= '0;
            pk_suflen1_q   <= '0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= accept && cur_ovf;

            if ((state_q == IDLE) && start) begin
                rem_q   <= n_levels;
                sl_q    <= SL_W'((total_coeff > 5'd10) && (trailing_ones != 2'd3));
                first_q <= 1'b1;
                adj_q   <= (trailing_ones != 2'd3);
                ptr_q   <= 1'b0;
                done_q  <= (n_levels == '0);
            end

            if (accept) begin
                rem_q   <= rem_q - 5'd1;
                sl_q    <= cur_sl_next;
                first_q <= 1'b0;
                if (pair_done) begin
                    ptr_q <= 1'b0;
                    if (ptr_q) begin
                        pk_enable_q  <= 2'b11;
                        pk_prefix0_q <= slot0_prefix_q;
                        pk_suffix0_q <= slot0_suffix_q;
                        pk_suflen0_q <= slot0_suflen_q;
                        pk_prefix1_q <= cur_prefix;
                        pk_suffix1_q <= cur_suffix;
                        pk_suflen1_q <= cur_suflen;
                    end else begin
                        pk_enable_q  <= 2'b01;
                        pk_prefix0_q <= cur_prefix;
                        pk_suffix0_q <= cur_suffix;
                        pk_suflen0_q <= cur_suflen;
                        pk_prefix1_q <= '0;
                        pk_suffix1_q <= '0;
                        pk_suflen1_q <= '0;
                    end
                end else begin
                    ptr_q          <= 1'b1;
                    slot0_prefix_q <= cur_prefix;
                    slot0_suffix_q <= cur_suffix;
                    slot0_suflen_q <= cur_suflen;
                end
            end

            if (handshake && (rem_q == '0)) begin
                done_q       <= 1'b1;
                pk_enable_q  <= '0;
                pk_prefix0_q <= '0;
                pk_prefix1_q <= '0;
                pk_suffix0_q <= '0;
                pk_suffix1_q <= '0;
                pk_suflen0_q <= '0;
                pk_suflen1_q <= '0;
            end
        end
    end

    assign pk_enable  = pk_enable_q;
    assign pk_prefix0 = pk_prefix0_q;
    assign pk_prefix1 = pk_prefix1_q;
    assign pk_suffix0 = pk_suffix0_q;
    assign pk_suffix1 = pk_suffix1_q;
    assign pk_suflen0 = pk_suflen0_q;
    assign pk_suflen1 = pk_suflen1_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_cavlc_level_sched.sv
// Self-checking bench for cavlc_level_sched. A level-coding model written with
// plain integer arithmetic predicts every packed pair; one compare process
// checks the packer outputs on every out_valid cycle.
module tb_cavlc_level_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        start;
    logic [4:0]  total_coeff;
    logic [1:0]  trailing_ones;
    logic        lvl_valid;
    logic [15:0] lvl_data;
    logic        lvl_ready;
    logic [1:0]  pk_enable;
    logic [4:0]  pk_prefix0, pk_prefix1;
    logic [14:0] pk_suffix0, pk_suffix1;
    logic [3:0]  pk_suflen0, pk_suflen1;
    logic        out_valid;
    logic        out_ready;
    logic        done;
    logic        err;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    typedef struct {
        int en;
        int p0, s0, l0;
        int p1, s1, l1;
    } pair_t;

    pair_t exp_q[$];
    pair_t cur_e;

    always #5 clk = ~clk;

    cavlc_level_sched dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .clr           (clr),
        .start         (start),
        .total_coeff   (total_coeff),
        .trailing_ones (trailing_ones),
        .lvl_valid     (lvl_valid),
        .lvl_data      (lvl_data),
        .lvl_ready     (lvl_ready),
        .pk_enable     (pk_enable),
        .pk_prefix0    (pk_prefix0),
        .pk_prefix1    (pk_prefix1),
        .pk_suffix0    (pk_suffix0),
        .pk_suffix1    (pk_suffix1),
        .pk_suflen0    (pk_suflen0),
        .pk_suflen1    (pk_suflen1),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .done          (done),
        .err           (err)
    );

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Level coding straight from the rules: integer levelCode, threshold
    // tests against 14/30 or 15*2^sl, then the suffixLength adaptation.
    function automatic void model_code(input int lvl, input int sl, input bit adj,
                                       output int prefix, output int suffix,
                                       output int suflen, output int sl_next,
                                       output bit ovf);
        int code, mag, esc, s1;
        bit is_esc;
        mag = (lvl < 0) ? -lvl : lvl;
        code = (lvl > 0) ? 2 * lvl - 2 : 2 * mag - 1;
        if (adj) code -= 2;
        prefix = 0; suffix = 0; suflen = 0; ovf = 0; is_esc = 0; esc = 0;
        if (sl == 0) begin
            if (code < 14) prefix = code;
            else if (code < 30) begin prefix = 14; suffix = code - 14; suflen = 4; end
            else begin is_esc = 1; esc = code - 30; end
        end else if (code < 15 * (1 << sl)) begin
            prefix = code / (1 << sl);
            suffix = code % (1 << sl);
            suflen = sl;
        end else begin
            is_esc = 1;
            esc = code - 15 * (1 << sl);
        end
        if (is_esc) begin
            prefix = 15;
            suflen = 12;
            if (esc > 4095) begin suffix = 4095; ovf = 1; end
            else suffix = esc;
        end
        s1 = (sl == 0) ? 1 : sl;
        sl_next = (mag > 3 * (1 << (s1 - 1)) && s1 < 6) ? s1 + 1 : s1;
    endfunction

    // Expands one block into the sequence of packed pairs it must produce.
    task automatic build_model(input int tc, input int t1, input int lv[$], output int errs);
        int sl, p, s, l, sn;
        bit o, have0;
        pair_t pr;
        sl = (tc > 10 && t1 < 3) ? 1 : 0;
        have0 = 0;
        errs = 0;
        pr = '{0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < lv.size(); i++) begin
            model_code(lv[i], sl, (i == 0) && (t1 < 3), p, s, l, sn, o);
            sl = sn;
            errs += int'(o);
            if (have0) begin
                pr.en = 3; pr.p1 = p; pr.s1 = s; pr.l1 = l;
                exp_q.push_back(pr);
                have0 = 0;
            end else if (i == lv.size() - 1) begin
                pr = '{1, p, s, l, 0, 0, 0};
                exp_q.push_back(pr);
            end else begin
                pr = '{0, p, s, l, 0, 0, 0};
                have0 = 1;
            end
        end
    endtask

    task automatic pin(input string name, input int lvl, input int sl, input bit adj,
                       input int ep, input int es, input int el, input int esn, input int eo);
        int p, s, l, sn;
        bit o;
        model_code(lvl, sl, adj, p, s, l, sn, o);
        check({name, "_prefix"}, p, ep);
        check({name, "_suffix"}, s, es);
        check({name, "_suflen"}, l, el);
        check({name, "_slnext"}, sn, esn);
        check({name, "_ovf"}, int'(o), eo);
    endtask

    // Compare process: every out_valid cycle must show the head pair.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (err)  err_cnt++;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                cur_e = exp_q[0];
                check("pk_enable",  int'(pk_enable),  cur_e.en);
                check("pk_prefix0", int'(pk_prefix0), cur_e.p0);
                check("pk_suffix0", int'(pk_suffix0), cur_e.s0);
                check("pk_suflen0", int'(pk_suflen0), cur_e.l0);
                check("pk_prefix1", int'(pk_prefix1), cur_e.p1);
                check("pk_suffix1", int'(pk_suffix1), cur_e.s1);
                check("pk_suflen1", int'(pk_suflen1), cur_e.l1);
                check("lvl_ready_in_send", int'(lvl_ready), 0);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic feed(input string name, input int lv[$]);
        bit ok;
        for (int i = 0; i < lv.size(); i++) begin
            lvl_valid = 1'b1;
            lvl_data  = 16'(lv[i]);
            ok = 0;
            for (int w = 0; w < 200 && !ok; w++) begin
                @(negedge clk);
                ok = lvl_ready;
            end
            if (!ok) check({name, "_accept_timeout"}, 0, 1);
            @(posedge clk);
            #1;
        end
        lvl_valid = 1'b0;
    endtask

    task automatic run_block(input string name, input int tc, input int t1, input int lv[$]);
        int errs, d0, e0, w;
        build_model(tc, t1, lv, errs);
        d0 = done_cnt;
        e0 = err_cnt;
        total_coeff   = 5'(tc);
        trailing_ones = 2'(t1);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        feed(name, lv);
        w = 0;
        while (done_cnt == d0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1;
        check({name, "_done_count"}, done_cnt - d0, 1);
        check({name, "_pairs_left"}, exp_q.size(), 0);
        check({name, "_err_count"}, err_cnt - e0, errs);
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lv[$];
        int errs, d0;
        bit ok;

        rst_n = 1'b1;
        clr = 1'b0;
        start = 1'b0;
        total_coeff = '0;
        trailing_ones = '0;
        lvl_valid = 1'b0;
        lvl_data = '0;
        out_ready = 1'b1;

        // Hand-computed values that pin the model itself.
        pin("pin_l3_first",   3,    0, 1,  2,    0,  0, 1, 0);
        pin("pin_lm2_sl1",   -2,    1, 0,  1,    1,  1, 1, 0);
        pin("pin_l8_sl0",     8,    0, 0, 14,    0,  4, 2, 0);
        pin("pin_l20_sl0",   20,    0, 0, 15,    8, 12, 2, 0);
        pin("pin_l5_sl1",     5,    1, 1,  3,    0,  1, 2, 0);
        pin("pin_l3000_sl6", 3000,  6, 0, 15, 4095, 12, 6, 1);

        // Reset state.
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_lvl_ready", int'(lvl_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_pk_enable", int'(pk_enable), 0);
        check("rst_pk_fields", int'(pk_prefix0) + int'(pk_prefix1) + int'(pk_suffix0)
              + int'(pk_suffix1) + int'(pk_suflen0) + int'(pk_suflen1), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic pair plus odd tail.
        lv = '{3, -2, 1};
        run_block("basic", 5, 2, lv);

        // sl=0 escape thresholds, then the sl=2 follow-up.
        lv = '{8, 20};
        run_block("esc_pair", 5, 3, lv);

        // Single-level blocks across the sl=0 code boundaries (13/14/29/30, max).
        begin
            int singles[6];
            singles = '{-7, 8, 15, -15, 16, 20};
            foreach (singles[k]) begin
                lv = '{singles[k]};
                run_block("sl0_single", 4, 3, lv);
            end
            lv = '{-32768};
            run_block("sl0_min_level", 4, 3, lv);
        end

        // sl initialised to 1 and grown by the first level.
        lv = '{5, -3, 2, 7, -1, 4, 1, -6, 2, 3, -9};
        run_block("sl_init", 12, 1, lv);

        // Climb to sl=6, then an overflowing escape.
        lv = '{100, 100, 100, 100, 100, 3000, 1, -1, 1, -1, 1};
        run_block("overflow", 11, 0, lv);

        // Backpressure: hold out_ready low for 5 SEND cycles.
        out_ready = 1'b0;
        lv = '{2, -4, 6, -1, 3, -2};
        fork
            run_block("backpressure", 6, 0, lv);
            begin
                ok = 0;
                for (int w = 0; w < 100 && !ok; w++) begin
                    @(negedge clk);
                    ok = out_valid;
                end
                check("bp_reached_send", int'(ok), 1);
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    check("bp_out_valid_held", int'(out_valid), 1);
                    check("bp_lvl_ready_low", int'(lvl_ready), 0);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join

        // Zero-level block: done one cycle after start, no output word.
        d0 = done_cnt;
        total_coeff = 5'd3;
        trailing_ones = 2'd3;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("zero_done_pulse", int'(done), 1);
        check("zero_no_out_valid", int'(out_valid), 0);
        @(negedge clk);
        check("zero_done_single", int'(done), 0);
        check("zero_no_out_valid2", int'(out_valid), 0);
        @(posedge clk);
        #1;
        check("zero_done_count", done_cnt - d0, 1);

        // Abort with clr while a pair is waiting in SEND.
        out_ready = 1'b0;
        lv = '{3, -2, 1};
        build_model(5, 2, lv, errs);
        total_coeff = 5'd5;
        trailing_ones = 2'd2;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lv = '{3, -2};
        feed("clr", lv);
        @(negedge clk);
        check("clr_in_send", int'(out_valid), 1);
        @(posedge clk);
        #1 clr = 1'b1;
        d0 = done_cnt;
        @(posedge clk);
        #1 clr = 1'b0;
        @(negedge clk);
        check("clr_out_valid", int'(out_valid), 0);
        check("clr_lvl_ready", int'(lvl_ready), 0);
        check("clr_pk_enable", int'(pk_enable), 0);
        check("clr_pk_fields", int'(pk_prefix0) + int'(pk_prefix1) + int'(pk_suffix0)
              + int'(pk_suffix1) + int'(pk_suflen0) + int'(pk_suflen1), 0);
        check("clr_err", int'(err), 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        check("clr_no_done", done_cnt - d0, 0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Block after abort runs normally.
        lv = '{-4, 9};
        run_block("after_clr", 2, 0, lv);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
